// File: rtl/tick_gen_pkg.sv
// Shared constants and helpers for the multi-channel clock-enable generator.
package tick_gen_pkg;

    // Common divisors for a 5 MHz system clock.
    localparam int unsigned DIV_1S    = 5_000_000;
    localparam int unsigned DIV_1MS   = 5_000;
    localparam int unsigned DIV_BLINK = 2_500_000;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int unsigned sel_width(input int unsigned ch);
        return (ch <= 1) ? 32'd1 : 32'($clog2(ch));
    endfunction

endpackage

// File: rtl/tick_gen_if.sv
// Control/status bundle between a tick_gen and whoever programs it.
interface tick_gen_if
    import tick_gen_pkg::*;
#(
    parameter int unsigned CH = 2,
    parameter int unsigned W  = 32
);
    localparam int unsigned SW = sel_width(CH);

    logic [CH-1:0] en;
    logic          div_we;
    logic [SW-1:0] div_sel;
    logic [W-1:0]  div_wdata;
    logic [CH-1:0] tick;
    logic [CH-1:0] sq;
    logic [CH-1:0] busy;

    modport master (
        output en, div_we, div_sel, div_wdata,
        input  tick, sq, busy
    );

    modport slave (
        input  en, div_we, div_sel, div_wdata,
        output tick, sq, busy
    );

endinterface

// File: rtl/tick_gen_ch.sv
// One divider channel: counter, active/pending divisor, tick pulse and square wave.
module tick_gen_ch
    import tick_gen_pkg::*;
#(
    parameter int unsigned W           = 32,
    parameter int unsigned DIV_DEFAULT = DIV_1S
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         cnt_en,
    input  logic         we,
    input  logic [W-1:0] wdata,
    output logic         tick,
    output logic         sq,
    output logic         busy
);

    logic [W-1:0] cnt;
    logic [W-1:0] div;
    logic [W-1:0] pend;
    logic [W-1:0] d_eff;
    logic         term;

    // Zero divisor acts as one; an out-of-range count is treated as terminal.
    always_comb begin
        d_eff = (div == '0) ? W'(1) : div;
        term  = (cnt >= (d_eff - W'(1)));
    end

    // Count, emit tick/sq, and swap in the pending divisor at safe points.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            div  <= W'(DIV_DEFAULT);
            pend <= '0;
            busy <= 1'b0;
            tick <= 1'b0;
            sq   <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (cnt_en) begin
                if (term) begin
                    cnt  <= '0;
                    tick <= 1'b1;
                    sq   <= ~sq;
                    if (busy) begin
                        div  <= pend;
                        busy <= 1'b0;
                    end
                end else begin
                    cnt <= cnt + W'(1);
                end
            end else if (!en && busy) begin
                div  <= pend;
                cnt  <= '0;
                busy <= 1'b0;
            end
            // A new write wins over a same-edge apply: it stays pending.
            if (we) begin
                pend <= wdata;
                busy <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/tick_gen.sv
// Multi-channel clock-enable generator with glitch-free divisor updates.
// Optional build macro TICK_GEN_CASCADE_EN chains channel i>0 onto tick[i-1].
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int unsigned CH          = 2,
    parameter int unsigned W           = 32,
    parameter int unsigned DIV_DEFAULT = DIV_1S
) (
    input  logic     clk,
    input  logic     rst_n,
    tick_gen_if.slave bus
);

    localparam int unsigned SW = sel_width(CH);

    logic [CH-1:0] cnt_en;
    logic [CH-1:0] tick_w;
    logic [CH-1:0] sq_w;
    logic [CH-1:0] busy_w;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic we;

        // Selects that match no channel fall through and are dropped.
        assign we = bus.div_we && (bus.div_sel == SW'(i));

`ifdef TICK_GEN_CASCADE_EN
        if (i == 0) begin : g_head
            assign cnt_en[i] = bus.en[i];
        end else begin : g_link
            assign cnt_en[i] = bus.en[i] && tick_w[i-1];
        end
`else
        assign cnt_en[i] = bus.en[i];
`endif

        tick_gen_ch #(
            .W           (W),
            .DIV_DEFAULT (DIV_DEFAULT)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (bus.en[i]),
            .cnt_en (cnt_en[i]),
            .we     (we),
            .wdata  (bus.div_wdata),
            .tick   (tick_w[i]),
            .sq     (sq_w[i]),
            .busy   (busy_w[i])
        );
    end

    assign bus.tick = tick_w;
    assign bus.sq   = sq_w;
    assign bus.busy = busy_w;

endmodule

// File: tb/tb_tick_gen.sv
// Bench for tick_gen: cycle scoreboard against a behavioural model plus directed cycle checks.
module tb_tick_gen;

    localparam int unsigned CH = 2;
    localparam int unsigned W  = 32;
    localparam int unsigned DD = 4;

    logic clk;
    logic rst_n;

    tick_gen_if #(.CH(CH), .W(W)) bus ();

    tick_gen #(.CH(CH), .W(W), .DIV_DEFAULT(DD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [CH-1:0] tick;
        logic [CH-1:0] sq;
        logic [CH-1:0] busy;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference state, one entry per channel.
    int m_cnt  [CH];
    int m_div  [CH];
    int m_pend [CH];
    bit m_busy [CH];
    bit m_tick [CH];
    bit m_sq   [CH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model one posedge using the inputs currently driven.
    // Channels are walked high to low so m_tick[i-1] still holds its pre-edge value.
    task automatic model_edge();
        int period;
        bit go;
        bit wr;
        for (int i = CH - 1; i >= 0; i--) begin
            if (!rst_n) begin
                m_cnt[i]  = 0;
                m_div[i]  = DD;
                m_pend[i] = 0;
                m_busy[i] = 0;
                m_tick[i] = 0;
                m_sq[i]   = 0;
            end else begin
                period = (m_div[i] == 0) ? 1 : m_div[i];
                go     = bus.en[i];
`ifdef TICK_GEN_CASCADE_EN
                if (i > 0) go = go && m_tick[i-1];
`endif
                wr = bus.div_we && (int'(bus.div_sel) == i);
                m_tick[i] = 0;
                if (go) begin
                    if (m_cnt[i] + 1 >= period) begin
                        m_cnt[i]  = 0;
                        m_tick[i] = 1;
                        m_sq[i]   = !m_sq[i];
                        if (m_busy[i]) begin
                            m_div[i]  = m_pend[i];
                            m_busy[i] = 0;
                        end
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end else if (!bus.en[i] && m_busy[i]) begin
                    m_div[i]  = m_pend[i];
                    m_cnt[i]  = 0;
                    m_busy[i] = 0;
                end
                if (wr) begin
                    m_pend[i] = int'(bus.div_wdata);
                    m_busy[i] = 1;
                end
            end
        end
    endtask

    // One clock: predict, push, clock, pop and compare.
    task automatic step();
        exp_t e;
        model_edge();
        for (int i = 0; i < CH; i++) begin
            e.tick[i] = m_tick[i];
            e.sq[i]   = m_sq[i];
            e.busy[i] = m_busy[i];
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check("sb_tick", 32'(bus.tick), 32'(e.tick));
            check("sb_sq",   32'(bus.sq),   32'(e.sq));
            check("sb_busy", 32'(bus.busy), 32'(e.busy));
        end
    endtask

    task automatic idle_inputs();
        bus.div_we    = 1'b0;
        bus.div_sel   = '0;
        bus.div_wdata = '0;
    endtask

    task automatic reset_dut();
        rst_n  = 1'b0;
        bus.en = '0;
        idle_inputs();
        step();
        step();
        check("rst_tick", 32'(bus.tick), 32'd0);
        check("rst_sq",   32'(bus.sq),   32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
    endtask

    task automatic write(input int sel, input int data);
        bus.div_we    = 1'b1;
        bus.div_sel   = 1'(sel);
        bus.div_wdata = W'(data);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst_n = 1'b0;
        bus.en = '0;
        idle_inputs();

        // Default divisor: ticks every 4 cycles, sq toggles on each.
        reset_dut();
        for (int c = 1; c <= 12; c++) begin
            bus.en = '1;
            step();
            check("a_tick0", 32'(bus.tick[0]), 32'(c % 4 == 0));
            if (c == 4) check("a_sq0_rise", 32'(bus.sq[0]), 32'd1);
            if (c == 8) check("a_sq0_fall", 32'(bus.sq[0]), 32'd0);
`ifndef TICK_GEN_CASCADE_EN
            check("a_tick1", 32'(bus.tick[1]), 32'(c % 4 == 0));
`endif
        end

        // Write 3 to channel 1 mid-period: applied at the terminal count.
        reset_dut();
        for (int c = 1; c <= 13; c++) begin
            bus.en = '1;
            idle_inputs();
            if (c == 2) write(1, 3);
            step();
`ifndef TICK_GEN_CASCADE_EN
            if (c == 2 || c == 3) check("b_busy1_hi", 32'(bus.busy[1]), 32'd1);
            if (c == 4) check("b_busy1_lo", 32'(bus.busy[1]), 32'd0);
            if (c >= 5) check("b_tick1", 32'(bus.tick[1]), 32'(c == 7 || c == 10 || c == 13));
`endif
        end

        // Back-to-back writes 6 then 2: last one wins.
        reset_dut();
        for (int c = 1; c <= 10; c++) begin
            bus.en = '1;
            idle_inputs();
            if (c == 1) write(0, 6);
            if (c == 2) write(0, 2);
            step();
            check("c_busy0", 32'(bus.busy[0]), 32'(c <= 3));
            check("c_tick0", 32'(bus.tick[0]), 32'(c == 4 || c == 6 || c == 8 || c == 10));
        end

        // Divisor 0 behaves as 1: tick stuck high, sq toggling each cycle.
        reset_dut();
        for (int c = 1; c <= 9; c++) begin
            bus.en = '1;
            idle_inputs();
            if (c == 1) write(0, 0);
            step();
            check("d_tick0", 32'(bus.tick[0]), 32'(c >= 4));
            check("d_sq0", 32'(bus.sq[0]), 32'(c >= 4 && ((c - 4) % 2 == 0)));
        end

        // en[0] dropped at cnt=2 for 5 cycles: count freezes and resumes.
        reset_dut();
        for (int c = 1; c <= 9; c++) begin
            idle_inputs();
            bus.en = (c >= 3 && c <= 7) ? 2'b10 : 2'b11;
            step();
            check("e_tick0", 32'(bus.tick[0]), 32'(c == 9));
        end

        // Pending write on a disabled channel applies on the next edge.
        reset_dut();
        for (int c = 1; c <= 12; c++) begin
            idle_inputs();
            bus.en = (c <= 2) ? 2'b01 : 2'b11;
            if (c == 1) write(1, 5);
            step();
            if (c == 1) check("f_busy1_hi", 32'(bus.busy[1]), 32'd1);
            if (c == 2) check("f_busy1_lo", 32'(bus.busy[1]), 32'd0);
`ifndef TICK_GEN_CASCADE_EN
            if (c >= 3) check("f_tick1", 32'(bus.tick[1]), 32'(c == 7 || c == 12));
`endif
        end

        // D0=2, D1=3: independent rates, or a 6-cycle chained rate when cascaded.
        reset_dut();
        for (int c = 1; c <= 29; c++) begin
            bus.en = '1;
            idle_inputs();
            if (c == 1) write(0, 2);
            if (c == 2) write(1, 3);
            step();
`ifdef TICK_GEN_CASCADE_EN
            if (c >= 17) check("g_tick1", 32'(bus.tick[1]), 32'(c == 17 || c == 23 || c == 29));
`else
            if (c >= 5 && c <= 16) check("g_tick1", 32'(bus.tick[1]), 32'(c == 7 || c == 10 || c == 13 || c == 16));
`endif
            if (c >= 4) check("g_tick0", 32'(bus.tick[0]), 32'(c % 2 == 0));
        end

        // Random enables, writes and occasional resets against the model.
        reset_dut();
        for (int c = 0; c < 400; c++) begin
            rst_n  = ($urandom_range(0, 99) != 0);
            bus.en = CH'($urandom_range(0, 3));
            idle_inputs();
            if ($urandom_range(0, 3) == 0)
                write(int'($urandom_range(0, 1)), int'($urandom_range(0, 6)));
            step();
        end
        rst_n = 1'b1;
        idle_inputs();

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
